pipeline_mult_tree: RTL and testbench
=====================================

// Module: pipeline_mult_tree
// PURPOSE
//  Parametrised pipelined product of NUM_IN operands, built as a binary tree of
//  registered multiplier levels. Adds a valid/ready handshake with backpressure,
//  signed/unsigned mode and reset. Sits in the datapath wherever a multi-operand
//  full-precision product is streamed, one result per cycle when not stalled.
// PARAMETERS
//  WIDTH    32  operand width in bits (>=2)
//  NUM_IN   4   operand count; power of two, >=2; LEVELS = log2(NUM_IN)
//  SIGNED   0   0: unsigned operands; 1: two's-complement operands and result
//  TAG_W    8   sideband tag width (used only with PMT_TAG_EN)
// PORTS
//  clk        in   1             rising-edge clock
//  rst_n      in   1             asynchronous active-low reset
//  in_valid   in   1             operand set present on in_data
//  in_ready   out  1             block accepts in_data this cycle
//  in_data    in   NUM_IN*WIDTH  operand i at [i*WIDTH +: WIDTH]
//  in_tag     in   TAG_W         sideband tag (PMT_TAG_EN only)
//  out_valid  out  1             out_data holds a product
//  out_ready  in   1             downstream accepts out_data this cycle
//  out_data   out  NUM_IN*WIDTH  full-precision product, never truncated
//  out_tag    out  TAG_W         tag of the product on out_data (PMT_TAG_EN only)
// BEHAVIOUR
//  - One clock (clk); reset rst_n is asynchronous, active-low.
//  - Reset: all stage valids, out_valid=0, out_data=0, out_tag=0, all stage
//    data regs=0; in_ready=1 from the first cycle after reset deasserts.
//  - Structure: level k (1..LEVELS) registers NUM_IN>>k products of width
//    WIDTH<<k, pairing adjacent level-(k-1) results (2j, 2j+1); level 0 = inputs.
//    Level LEVELS feeds an output register.
//  - Latency: LEVELS+1 cycles from accept to out_valid (default: 3).
//  - Throughput: 1 product/cycle while out_ready=1.
//  - Stall: advance = !out_valid | out_ready; in_ready = advance (comb.).
//    All stage regs (data+valid) load only when advance=1; otherwise hold.
//    Bubbles are not collapsed; they travel with the pipe.
//  - Accept: in_valid & in_ready. in_valid=0 with advance=1 inserts a bubble.
//  - Output: out_data/out_valid/out_tag stable while out_valid & !out_ready.
//  - SIGNED=1: each level sign-extends to 2x width before multiplying; result
//    is the exact two's-complement product. SIGNED=0: zero-extend.
//  - Width rule: product of NUM_IN WIDTH-bit values fits NUM_IN*WIDTH bits in
//    both modes; no overflow/saturation logic exists.
//  - Reset mid-operation: all in-flight products discarded, no output for them;
//    pipe restarts empty.
//  - Simultaneous out_ready=1 and new accept: output reg replaced same edge.
//  - Combinational paths: out_ready -> in_ready only; no in_* -> out_* path.
// CONFIGURATION
//  - PMT_TAG_EN defined: in_tag registered alongside data through every level
//    and output reg, same stall/reset rules; out_tag = tag of out_data.
//  - PMT_TAG_EN undefined: in_tag/out_tag ports absent; no tag registers.
// TESTING (defaults WIDTH=32, NUM_IN=4 unless stated)
//  1. Accept {2,3,4,5} at cycle 0, out_ready=1 -> out_valid at cycle 3,
//     out_data=120, one cycle only.
//  2. All operands 0xFFFFFFFF, SIGNED=0 ->
//     out_data=0xFFFFFFFC_00000005_FFFFFFFC_00000001.
//  3. SIGNED=1: {-2,3,-4,5} -> 120; {-1,1,1,1} -> 128'hFFFF..FF (-1).
//  4. Stream 10 sets back-to-back, out_ready low cycles 4-8 -> in_ready low
//     same cycles, out_data held, all 10 products in order, none lost/duped.
//  5. rst_n low mid-stream with 3 in flight -> out_valid=0, out_data=0
//     immediately; no stale products after release; next accept ok.
//  6. PMT_TAG_EN, NUM_IN=8, WIDTH=8: tags 0..15 with random stalls ->
//     out_tag matches each product's accept tag, latency 4.

Source files
------------

// File: rtl/pipeline_mult_tree.sv
// Pipelined binary-tree product of NUM_IN operands with valid/ready backpressure.
// Optional sideband tag path enabled by defining PMT_TAG_EN.
module pipeline_mult_tree #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4,
    parameter int SIGNED = 0,
    parameter int TAG_W  = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [NUM_IN*WIDTH-1:0] out_data
`ifdef PMT_TAG_EN
    ,
    input  logic [TAG_W-1:0]        in_tag,
    output logic [TAG_W-1:0]        out_tag
`endif
);

    localparam int LEVELS = $clog2(NUM_IN);
    localparam int DW     = NUM_IN * WIDTH;

    logic                    advance;
    logic [LEVELS:1][DW-1:0] stage_d;
    logic [LEVELS:1][DW-1:0] stage_q;
    logic [LEVELS:1]         vld_d;
    logic [LEVELS:1]         vld_q;
    logic [DW-1:0]           out_data_q;
    logic                    out_valid_q;

    // The whole pipe moves as one; bubbles are never squeezed out.
    assign advance   = !out_valid_q || out_ready;
    assign in_ready  = advance;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

    generate
        for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
            localparam int PW = WIDTH << (k - 1);
            logic [DW-1:0] src;

            if (k == 1) begin : g_first
                assign src      = in_data;
                assign vld_d[k] = in_valid;
            end else begin : g_inner
                assign src      = stage_q[k-1];
                assign vld_d[k] = vld_q[k-1];
            end

            for (genvar j = 0; j < (NUM_IN >> k); j++) begin : g_pair
                logic [PW-1:0]   a;
                logic [PW-1:0]   b;
                logic [2*PW-1:0] a_x;
                logic [2*PW-1:0] b_x;

                assign a = src[(2*j)*PW +: PW];
                assign b = src[(2*j+1)*PW +: PW];

                // Low 2*PW bits of the extended product are exact in both modes.
                if (SIGNED != 0) begin : g_sx
                    assign a_x = {{PW{a[PW-1]}}, a};
                    assign b_x = {{PW{b[PW-1]}}, b};
                end else begin : g_zx
                    assign a_x = {{PW{1'b0}}, a};
                    assign b_x = {{PW{1'b0}}, b};
                end

                assign stage_d[k][(2*j)*PW +: 2*PW] = a_x * b_x;
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q     <= '0;
            vld_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else if (advance) begin
            stage_q     <= stage_d;
            vld_q       <= vld_d;
            out_data_q  <= stage_q[LEVELS];
            out_valid_q <= vld_q[LEVELS];
        end
    end

`ifdef PMT_TAG_EN
    logic [LEVELS:1][TAG_W-1:0] tag_d;
    logic [LEVELS:1][TAG_W-1:0] tag_q;
    logic [TAG_W-1:0]           out_tag_q;

    generate
        for (genvar k = 1; k <= LEVELS; k++) begin : g_tag
            if (k == 1) begin : g_first
                assign tag_d[k] = in_tag;
            end else begin : g_inner
                assign tag_d[k] = tag_q[k-1];
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_q     <= '0;
            out_tag_q <= '0;
        end else if (advance) begin
            tag_q     <= tag_d;
            out_tag_q <= tag_q[LEVELS];
        end
    end

    assign out_tag = out_tag_q;
`endif

endmodule

// File: tb/tb_pipeline_mult_tree.sv
// Scoreboard bench for pipeline_mult_tree: unsigned and signed instances
// share stimulus; the tag scenario builds only with PMT_TAG_EN.
module tb_pipeline_mult_tree;

    localparam int W  = 32;
    localparam int N  = 4;
    localparam int DW = W * N;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          out_ready;
    logic [DW-1:0] in_data;
    logic          u_ir, u_ov, s_ir, s_ov;
    logic [DW-1:0] u_od, s_od;

    always #5 clk = ~clk;

`ifdef PMT_TAG_EN
    logic [7:0] in_tag, u_ot, s_ot;
`endif

    pipeline_mult_tree #(.WIDTH(W), .NUM_IN(N), .SIGNED(0)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(u_ir), .in_data(in_data),
        .out_valid(u_ov), .out_ready(out_ready), .out_data(u_od)
`ifdef PMT_TAG_EN
        , .in_tag(in_tag), .out_tag(u_ot)
`endif
    );

    pipeline_mult_tree #(.WIDTH(W), .NUM_IN(N), .SIGNED(1)) s_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(s_ir), .in_data(in_data),
        .out_valid(s_ov), .out_ready(out_ready), .out_data(s_od)
`ifdef PMT_TAG_EN
        , .in_tag(in_tag), .out_tag(s_ot)
`endif
    );

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [DW-1:0] qu[$];
    logic [DW-1:0] qs[$];
    logic [DW-1:0] e;

    bit            ov_u, ov_s, ir_u, ir_s;
    logic [DW-1:0] od_u, od_s;

    function automatic logic [DW-1:0] model(input logic [DW-1:0] d, input bit sgn);
        logic [DW-1:0] p;
        logic [W-1:0]  op;
        logic [DW-1:0] x;
        p = 1;
        for (int i = 0; i < N; i++) begin
            op = d[i*W +: W];
            x  = sgn ? {{(DW-W){op[W-1]}}, op} : {{(DW-W){1'b0}}, op};
            p  = p * x;
        end
        return p;
    endfunction

    // One clock of stimulus: samples outputs, drives inputs, samples in_ready.
    task automatic cyc(input bit v, input logic [DW-1:0] d, input bit r);
        @(negedge clk);
        ov_u = u_ov; od_u = u_od;
        ov_s = s_ov; od_s = s_od;
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        #1;
        ir_u = u_ir;
        ir_s = s_ir;
    endtask

    function automatic logic [DW-1:0] pack4(input int a, b, c, d);
        return {d[W-1:0], c[W-1:0], b[W-1:0], a[W-1:0]};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
`ifdef PMT_TAG_EN
        in_tag = '0;
`endif
        #12;
        total_cnt++;
        if (u_ov !== 1'b0 || s_ov !== 1'b0) $display("FAIL reset_valid got=%b/%b exp=0", u_ov, s_ov);
        else pass_cnt++;
        total_cnt++;
        if (u_od !== '0 || s_od !== '0) $display("FAIL reset_data got=%h exp=0", u_od);
        else pass_cnt++;
        @(negedge clk); rst_n = 1'b1;
        cyc(0, '0, 0);
        total_cnt++;
        if (ir_u !== 1'b1 || ir_s !== 1'b1) $display("FAIL reset_in_ready got=%b exp=1", ir_u);
        else pass_cnt++;
    endtask

    task automatic test_latency();
        logic [DW-1:0] d;
        d = pack4(2, 3, 4, 5);
        cyc(1, d, 1);
        if (ir_u) begin qu.push_back(model(d, 0)); qs.push_back(model(d, 1)); end
        total_cnt++;
        if (ov_u !== 1'b0) $display("FAIL lat_c0_valid got=%b exp=0", ov_u);
        else pass_cnt++;
        for (int c = 1; c <= 6; c++) begin
            cyc(0, '0, 1);
            total_cnt++;
            if (ov_u !== (c == 3)) $display("FAIL lat_valid_c%0d got=%b exp=%b", c, ov_u, c == 3);
            else pass_cnt++;
            if (ov_u) begin
                total_cnt++;
                e = qu.pop_front();
                if (od_u !== e || e !== 128'd120) $display("FAIL lat_data got=%h exp=%h", od_u, e);
                else pass_cnt++;
            end
            if (ov_s) begin
                total_cnt++;
                e = qs.pop_front();
                if (od_s !== e) $display("FAIL lat_data_s got=%h exp=%h", od_s, e);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_operands();
        logic [DW-1:0] tbl[4];
        tbl[0] = pack4(2, 3, 4, 5);
        tbl[1] = {DW{1'b1}};
        tbl[2] = pack4(-2, 3, -4, 5);
        tbl[3] = pack4(-1, 1, 1, 1);
        for (int c = 0; c < 30 && (c < 4 || qu.size() != 0 || qs.size() != 0); c++) begin
            cyc(c < 4, (c < 4) ? tbl[c] : '0, 1);
            if (c < 4 && ir_u) begin qu.push_back(model(tbl[c], 0)); qs.push_back(model(tbl[c], 1)); end
            if (ov_u) begin
                total_cnt++;
                if (qu.size() == 0) $display("FAIL ops_u spurious got=%h", od_u);
                else begin
                    e = qu.pop_front();
                    if (od_u !== e) $display("FAIL ops_u got=%h exp=%h", od_u, e);
                    else pass_cnt++;
                end
            end
            if (ov_s) begin
                total_cnt++;
                if (qs.size() == 0) $display("FAIL ops_s spurious got=%h", od_s);
                else begin
                    e = qs.pop_front();
                    if (od_s !== e) $display("FAIL ops_s got=%h exp=%h", od_s, e);
                    else pass_cnt++;
                end
            end
        end
        total_cnt++;
        if (qu.size() != 0 || qs.size() != 0) $display("FAIL ops_drain left=%0d exp=0", qu.size());
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int            sent, recv, stall_err, held_err, rdy_err;
        bit            r, pv, pr;
        logic [DW-1:0] d, pd;
        sent = 0; recv = 0; stall_err = 0; held_err = 0; rdy_err = 0;
        pv = 0; pr = 1; pd = '0;
        d = {$urandom, $urandom, $urandom, $urandom};
        for (int c = 0; c < 60 && recv < 10; c++) begin
            r = !(c >= 4 && c <= 8);
            cyc(sent < 10, d, r);
            if (ir_u !== (!ov_u || r)) rdy_err++;
            if (c >= 4 && c <= 8 && ir_u) stall_err++;
            if (pv && !pr && (!ov_u || od_u !== pd)) held_err++;
            pv = ov_u; pr = r; pd = od_u;
            if (sent < 10 && ir_u) begin
                qu.push_back(model(d, 0)); qs.push_back(model(d, 1));
                sent++;
                d = {$urandom, $urandom, $urandom, $urandom};
            end
            if (ov_u && r) begin
                total_cnt++; recv++;
                if (qu.size() == 0) $display("FAIL b2b_u spurious got=%h", od_u);
                else begin
                    e = qu.pop_front();
                    if (od_u !== e) $display("FAIL b2b_u got=%h exp=%h", od_u, e);
                    else pass_cnt++;
                end
            end
            if (ov_s && r) begin
                total_cnt++;
                if (qs.size() == 0) $display("FAIL b2b_s spurious got=%h", od_s);
                else begin
                    e = qs.pop_front();
                    if (od_s !== e) $display("FAIL b2b_s got=%h exp=%h", od_s, e);
                    else pass_cnt++;
                end
            end
        end
        total_cnt++;
        if (recv != 10 || qu.size() != 0) $display("FAIL b2b_count got=%0d exp=10", recv);
        else pass_cnt++;
        total_cnt++;
        if (stall_err != 0) $display("FAIL b2b_in_ready_low got=%0d exp=0", stall_err);
        else pass_cnt++;
        total_cnt++;
        if (held_err != 0) $display("FAIL b2b_hold got=%0d exp=0", held_err);
        else pass_cnt++;
        total_cnt++;
        if (rdy_err != 0) $display("FAIL b2b_in_ready_eq got=%0d exp=0", rdy_err);
        else pass_cnt++;
    endtask

    task automatic test_mid_reset();
        int            stale;
        logic [DW-1:0] d;
        for (int i = 0; i < 3; i++) cyc(1, pack4(i + 2, 7, 9, 11), 1);
        @(posedge clk); #2;
        total_cnt++;
        if (u_ov !== 1'b1) $display("FAIL mrst_pre_valid got=%b exp=1", u_ov);
        else pass_cnt++;
        rst_n = 1'b0; in_valid = 1'b0;
        #1;
        total_cnt++;
        if (u_ov !== 1'b0 || s_ov !== 1'b0) $display("FAIL mrst_valid got=%b exp=0", u_ov);
        else pass_cnt++;
        total_cnt++;
        if (u_od !== '0 || s_od !== '0) $display("FAIL mrst_data got=%h exp=0", u_od);
        else pass_cnt++;
        qu.delete(); qs.delete();
        @(negedge clk); rst_n = 1'b1;
        stale = 0;
        for (int c = 0; c < 6; c++) begin
            cyc(0, '0, 1);
            if (ov_u || ov_s) stale++;
        end
        total_cnt++;
        if (stale != 0) $display("FAIL mrst_stale got=%0d exp=0", stale);
        else pass_cnt++;
        d = pack4(-3, 6, 10, 1000);
        cyc(1, d, 1);
        if (ir_u) begin qu.push_back(model(d, 0)); qs.push_back(model(d, 1)); end
        for (int c = 0; c < 20 && (qu.size() != 0 || qs.size() != 0); c++) begin
            cyc(0, '0, 1);
            if (ov_u) begin
                total_cnt++;
                e = qu.pop_front();
                if (od_u !== e) $display("FAIL mrst_next_u got=%h exp=%h", od_u, e);
                else pass_cnt++;
            end
            if (ov_s) begin
                total_cnt++;
                e = qs.pop_front();
                if (od_s !== e) $display("FAIL mrst_next_s got=%h exp=%h", od_s, e);
                else pass_cnt++;
            end
        end
        total_cnt++;
        if (qu.size() != 0 || qs.size() != 0) $display("FAIL mrst_drain left=%0d exp=0", qu.size());
        else pass_cnt++;
    endtask

    task automatic test_random();
        bit            v, r;
        logic [DW-1:0] d;
        for (int c = 0; c < 140; c++) begin
            v = (c < 100) && ($urandom_range(0, 3) != 0);
            r = (c >= 100) || ($urandom_range(0, 2) != 0);
            d = {$urandom, $urandom, $urandom, $urandom};
            if ($urandom_range(0, 3) == 0) d = pack4($urandom_range(0, 9) - 5, 3, -7, $urandom_range(0, 99));
            cyc(v, d, r);
            if (v && ir_u) begin qu.push_back(model(d, 0)); qs.push_back(model(d, 1)); end
            if (ov_u && r) begin
                total_cnt++;
                if (qu.size() == 0) $display("FAIL rnd_u spurious got=%h", od_u);
                else begin
                    e = qu.pop_front();
                    if (od_u !== e) $display("FAIL rnd_u got=%h exp=%h", od_u, e);
                    else pass_cnt++;
                end
            end
            if (ov_s && r) begin
                total_cnt++;
                if (qs.size() == 0) $display("FAIL rnd_s spurious got=%h", od_s);
                else begin
                    e = qs.pop_front();
                    if (od_s !== e) $display("FAIL rnd_s got=%h exp=%h", od_s, e);
                    else pass_cnt++;
                end
            end
        end
        total_cnt++;
        if (qu.size() != 0 || qs.size() != 0) $display("FAIL rnd_drain left=%0d exp=0", qu.size());
        else pass_cnt++;
    endtask

`ifdef PMT_TAG_EN
    logic        t_iv, t_ir, t_or, t_ov;
    logic [63:0] t_id, t_od;
    logic [7:0]  t_it, t_ot;

    pipeline_mult_tree #(.WIDTH(8), .NUM_IN(8), .SIGNED(0), .TAG_W(8)) t_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(t_iv), .in_ready(t_ir), .in_data(t_id),
        .out_valid(t_ov), .out_ready(t_or), .out_data(t_od),
        .in_tag(t_it), .out_tag(t_ot)
    );

    initial begin t_iv = 1'b0; t_or = 1'b0; t_id = '0; t_it = '0; end

    task automatic test_tags();
        logic [71:0] tq[$];
        logic [71:0] te;
        logic [63:0] p;
        int          sent, recv, acc_c, out_c;
        bit          ov;
        logic [63:0] od;
        logic [7:0]  ot;
        sent = 0; recv = 0; acc_c = -1; out_c = -1;
        for (int c = 0; c < 300 && recv < 16; c++) begin
            @(negedge clk);
            ov = t_ov; od = t_od; ot = t_ot;
            if (ov && out_c < 0) out_c = c;
            t_or = $urandom_range(0, 2) != 0;
            t_iv = sent < 16;
            t_id = {$urandom, $urandom};
            t_it = sent[7:0];
            #1;
            if (t_iv && t_ir) begin
                p = 1;
                for (int i = 0; i < 8; i++) p = p * {56'd0, t_id[i*8 +: 8]};
                tq.push_back({t_it, p});
                if (acc_c < 0) acc_c = c;
                sent++;
            end
            if (ov && t_or) begin
                total_cnt++; recv++;
                te = tq.pop_front();
                if ({ot, od} !== te) $display("FAIL tag got=%h/%h exp=%h", ot, od, te);
                else pass_cnt++;
            end
        end
        t_iv = 1'b0;
        total_cnt++;
        if (recv != 16) $display("FAIL tag_count got=%0d exp=16", recv);
        else pass_cnt++;
        total_cnt++;
        if (out_c - acc_c != 4) $display("FAIL tag_latency got=%0d exp=4", out_c - acc_c);
        else pass_cnt++;
    endtask
`endif

    initial begin
        test_reset();
        test_latency();
        test_operands();
        test_back_to_back();
        test_mid_reset();
        test_random();
`ifdef PMT_TAG_EN
        test_tags();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
